// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller driving a dual-port RAM with a 2-entry output buffer
module dpram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic              write_enable_A,
  output logic [7:0]        address_A,
  output logic [DATA_W-1:0] data_in_A,
  output logic              write_enable_B,
  output logic [7:0]        address_B,
  output logic [DATA_W-1:0] data_in_B,
  input  logic [DATA_W-1:0] data_out_B
);

  localparam int DEPTH = 1 << ADDR_W;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   ram_occ;
  logic              inflight;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic              push;
  logic              pop;
  logic              ram_empty;
  logic              rd_issue;
  logic [2:0]        pending;

  assign ram_occ   = wptr - rptr;
  assign ram_empty = (wptr == rptr);
  assign full      = !reset && (ram_occ == (ADDR_W+1)'(DEPTH));
  assign in_ready  = !full && !reset;
  assign push      = in_valid && in_ready;
  assign out_valid = !reset && (buf_cnt != 2'd0);
  assign out_data  = reset ? '0 : buf0;
  assign pop       = out_valid && out_ready;

  // A read is only issued when the buffer is guaranteed a free slot on return.
  assign pending  = {2'b00, inflight} + {1'b0, buf_cnt} - {2'b00, pop};
  assign rd_issue = !reset && !ram_empty && (pending < 3'd2);

  assign count = reset ? '0 : ({1'b0, ram_occ}
                              + {{(ADDR_W+1){1'b0}}, inflight}
                              + {{ADDR_W{1'b0}}, buf_cnt});
  assign empty = (count == '0);

  assign write_enable_A = push;
  assign address_A      = reset ? 8'd0 : {{(8-ADDR_W){1'b0}}, wptr[ADDR_W-1:0]};
  assign data_in_A      = in_data;
  assign write_enable_B = 1'b0;
  assign address_B      = reset ? 8'd0 : {{(8-ADDR_W){1'b0}}, rptr[ADDR_W-1:0]};
  assign data_in_B      = '0;

  // Pointer advance and read-in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)     wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;
      inflight <= rd_issue;
    end
  end

  // Output buffer: capture returning RAM data, shift on pop, buf0 is the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= data_out_B;
          else                 buf1 <= data_out_B;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= data_out_B;
          end else begin
            buf0 <= buf1;
            buf1 <= data_out_B;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
